work_loader: RTL
================

Name: work_loader

Overview:
- Downstream of the SDRAM memory manager.
- Accepts the 32-bit words the manager streams out after it finds the 0xAAAA0000 start marker, and assembles them into a mining job: an 80-byte header plus a target/check area.
- Dispatches the job to the SHA-256 mining core and waits for the core to finish.
- Returns a two-word result (status, nonce) to the manager, which writes it back to SDRAM.

Parameters:
- DATAWIDTH, 32, word width of the stream, the result and the core read port.
- NUM_WORDS, 24, words per job (0..19 header, word 19 = start nonce, 20..23 target/check).
- IDXWIDTH, 5, width of the word index; must satisfy 2^IDXWIDTH >= NUM_WORDS.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_data  in  DATAWIDTH  input word.
- in_ready  out  1  loader accepts a word. A transfer occurs when in_valid && in_ready.
- job_abort  in  1  synchronous abort: discard the current job and return to LOAD.
- core_rd_addr  in  IDXWIDTH  core read index into the job buffer.
- core_rd_data  out  DATAWIDTH  combinational read of the job buffer at core_rd_addr.
- core_start  out  1  one-cycle pulse that starts the mining core.
- core_done  in  1  core finished (pulse or level; only the first cycle counts).
- core_found  in  1  valid with core_done: the core found a winning nonce.
- core_nonce  in  DATAWIDTH  valid with core_done: the nonce found.
- result_valid  out  1  result word valid.
- result_data  out  DATAWIDTH  result word.
- result_ready  in  1  consumer accepts the result word.
- busy  out  1  high in any state other than LOAD.
- word_count  out  IDXWIDTH  number of words loaded so far (used for the debug display).

Behaviour:
- Reset values:
  - state = LOAD, word_count = 0, in_ready = 1.
  - core_start = 0, result_valid = 0, result_data = 0, busy = 0.
  - Buffer contents are undefined; the buffer is not reset.
- LOAD:
  - in_ready = 1.
  - Each transfer writes buf[word_count] <= in_data, then word_count++.
  - The transfer that fills word NUM_WORDS-1 moves to DISPATCH on the next cycle and in_ready drops in that same next cycle.
  - in_valid while in_ready = 0 is ignored; no data is lost or overwritten.
- DISPATCH:
  - Assert core_start for exactly 1 cycle, then go to RUN.
  - Latency from the last accepted word to core_start = 1 cycle.
- RUN:
  - Wait for core_done.
  - On the first core_done cycle, latch status = core_found ? 0x5555000F : 0x55550000 and latch nonce = core_nonce.
  - Then go to RPT_STATUS.
  - core_done outside RUN is ignored.
- RPT_STATUS:
  - result_valid = 1, result_data = status.
  - On result_ready, go to RPT_NONCE.
- RPT_NONCE:
  - result_valid = 1, result_data = nonce (0 when not found).
  - On result_ready, clear word_count and go to LOAD.
- Result handshake:
  - result_data is held stable while result_valid && !result_ready.
  - result_ready while result_valid = 0 is ignored.
- job_abort:
  - Takes effect in any state.
  - Next cycle: state = LOAD, word_count = 0, result_valid = 0, core_start = 0.
  - Abort wins over a simultaneous transfer, core_done or result handshake.
- Read port:
  - core_rd_data = buf[core_rd_addr].
  - core_rd_addr >= NUM_WORDS returns 0.
  - Reading during LOAD returns whatever is currently stored; the core must only read after core_start.
- Counter arithmetic:
  - word_count never exceeds NUM_WORDS-1 while in LOAD; no wrap-around.
- Reset asserted mid-job: all outputs return to their reset values immediately (asynchronous).

Optional Feature:
- Macro: WORK_LOADER_CHECKSUM_EN.
- Defined:
  - Word NUM_WORDS-1 is a checksum equal to the XOR of words 0..NUM_WORDS-2.
  - A running XOR is accumulated during LOAD.
  - On mismatch, skip DISPATCH/RUN: status = 0xEEEE0000, nonce = 0, go straight to RPT_STATUS.
  - On match, behaviour is unchanged from the non-checksum case.
- Undefined: no checksum logic; word NUM_WORDS-1 is stored as ordinary data.

Test Plan:
- Load 24 words 0x00000001..0x00000018 with in_valid held high → in_ready falls after the 24th word; core_start pulses exactly once, 1 cycle later; core_rd_data at addr 19 = 0x00000014.
- In RUN, drive core_done=1, core_found=1, core_nonce=0x1234ABCD, with result_ready=1 → result words 0x5555000F then 0x1234ABCD; then back to LOAD with word_count=0.
- core_found=0, with result_ready low for 5 cycles → result_data stays 0x55550000 for all 5 cycles; then nonce word 0x00000000.
- Assert job_abort after 10 words are loaded; then load a full new job → new data at indices 0..9; exactly one core_start.
- Assert reset during RPT_NONCE → result_valid=0 immediately; in_ready=1, busy=0 after reset is released.
- With WORK_LOADER_CHECKSUM_EN defined, send a corrupted word 23 → no core_start; result words 0xEEEE0000 then 0x00000000. With a correct checksum → normal dispatch.

Source files
------------

// File: rtl/work_loader.sv
// Mining job loader: collects a NUM_WORDS job from the SDRAM manager, starts the SHA-256 core,
// and reports (status, nonce). Define WORK_LOADER_CHECKSUM_EN to verify the trailing XOR checksum word.
//
// state        | meaning
// S_LOAD       | accepting job words into the buffer
// S_DISPATCH   | one-cycle core_start pulse
// S_RUN        | waiting for core_done
// S_RPT_STATUS | presenting the status word
// S_RPT_NONCE  | presenting the nonce word
module work_loader #(
   parameter int DATAWIDTH = 32,
   parameter int NUM_WORDS = 24,
   parameter int IDXWIDTH  = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [DATAWIDTH-1:0] in_data,
   output logic                 in_ready,
   input  logic                 job_abort,
   input  logic [IDXWIDTH-1:0]  core_rd_addr,
   output logic [DATAWIDTH-1:0] core_rd_data,
   output logic                 core_start,
   input  logic                 core_done,
   input  logic                 core_found,
   input  logic [DATAWIDTH-1:0] core_nonce,
   output logic                 result_valid,
   output logic [DATAWIDTH-1:0] result_data,
   input  logic                 result_ready,
   output logic                 busy,
   output logic [IDXWIDTH-1:0]  word_count
);

   localparam logic [DATAWIDTH-1:0] STAT_FOUND = DATAWIDTH'(32'h5555_000F);
   localparam logic [DATAWIDTH-1:0] STAT_NONE  = DATAWIDTH'(32'h5555_0000);
`ifdef WORK_LOADER_CHECKSUM_EN
   localparam logic [DATAWIDTH-1:0] STAT_CSUM  = DATAWIDTH'(32'hEEEE_0000);
`endif

   typedef enum logic [2:0] {
      S_LOAD,
      S_DISPATCH,
      S_RUN,
      S_RPT_STATUS,
      S_RPT_NONCE
   } state_t;

   state_t                state_q, state_d;
   logic [IDXWIDTH-1:0]   count_q, count_d;
   logic [DATAWIDTH-1:0]  status_q, status_d;
   logic [DATAWIDTH-1:0]  nonce_q, nonce_d;
   logic [DATAWIDTH-1:0]  job_mem [NUM_WORDS];
   logic                  wr_en;
   logic                  last_word;
`ifdef WORK_LOADER_CHECKSUM_EN
   logic [DATAWIDTH-1:0]  csum_q, csum_d;
`endif

   // An abort in the same cycle as a transfer discards the word.
   assign wr_en     = (state_q == S_LOAD) && in_valid && !job_abort;
   assign last_word = (count_q == IDXWIDTH'(NUM_WORDS - 1));

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      status_d = status_q;
      nonce_d  = nonce_q;
`ifdef WORK_LOADER_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      if (job_abort) begin
         state_d = S_LOAD;
         count_d = '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (in_valid) begin
                  count_d = count_q + IDXWIDTH'(1);
`ifdef WORK_LOADER_CHECKSUM_EN
                  csum_d  = (count_q == '0) ? in_data : (csum_q ^ in_data);
                  if (last_word) begin
                     if (in_data != csum_q) begin
                        status_d = STAT_CSUM;
                        nonce_d  = '0;
                        state_d  = S_RPT_STATUS;
                     end else begin
                        state_d  = S_DISPATCH;
                     end
                  end
`else
                  if (last_word) state_d = S_DISPATCH;
`endif
               end
            end
            S_DISPATCH: state_d = S_RUN;
            S_RUN: begin
               if (core_done) begin
                  status_d = core_found ? STAT_FOUND : STAT_NONE;
                  nonce_d  = core_found ? core_nonce : '0;
                  state_d  = S_RPT_STATUS;
               end
            end
            S_RPT_STATUS: begin
               if (result_ready) state_d = S_RPT_NONCE;
            end
            S_RPT_NONCE: begin
               if (result_ready) begin
                  state_d = S_LOAD;
                  count_d = '0;
               end
            end
            default: begin
               state_d = S_LOAD;
               count_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_LOAD;
         count_q  <= '0;
         status_q <= '0;
         nonce_q  <= '0;
`ifdef WORK_LOADER_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         status_q <= status_d;
         nonce_q  <= nonce_d;
`ifdef WORK_LOADER_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

   // Job buffer is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) job_mem[count_q] <= in_data;
   end

   assign core_rd_data = (int'(core_rd_addr) < NUM_WORDS) ? job_mem[core_rd_addr] : '0;

   assign in_ready     = (state_q == S_LOAD);
   assign busy         = (state_q != S_LOAD);
   assign core_start   = (state_q == S_DISPATCH);
   assign result_valid = (state_q == S_RPT_STATUS) || (state_q == S_RPT_NONCE);
   assign word_count   = count_q;

   always_comb begin
      result_data = '0;
      if (state_q == S_RPT_STATUS)     result_data = status_q;
      else if (state_q == S_RPT_NONCE) result_data = nonce_q;
   end

endmodule
